// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file types and constants.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/rv32i_scoreboard.sv
// Pending-writeback scoreboard: busy bits per register plus RAW hazard stall.
module rv32i_scoreboard
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_en_i,
  input  reg_addr_t           wb_reg_i,
  input  reg_addr_t           rs1_reg_i,
  input  reg_addr_t           rs2_reg_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic                issue_en_i,
  input  reg_addr_t           issue_rd_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_mask_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic haz1, haz2, accept;

  // A writeback to the source in this cycle resolves the hazard via the bypass.
  always_comb begin
    haz1 = rs1_used_i && (rs1_reg_i != ZERO_REG) && busy_q[rs1_reg_i]
           && !(wb_en_i && (wb_reg_i == rs1_reg_i));
    haz2 = rs2_used_i && (rs2_reg_i != ZERO_REG) && busy_q[rs2_reg_i]
           && !(wb_en_i && (wb_reg_i == rs2_reg_i));
    stall_o = reset && (haz1 || haz2);
    accept  = issue_en_i && !stall_o && reset;
  end

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i)
      busy_d[wb_reg_i] = 1'b0;
    if (accept && (issue_rd_i != ZERO_REG))
      busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_mask_o = busy_q;

endmodule

// File: rtl/rv32i_regfile_sb.sv
// RV32I integer register file with write-through read bypass, retired-write
// counter and in-flight write scoreboard.
module rv32i_regfile_sb
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_en_in,
  input  reg_addr_t           wb_reg_in,
  input  word_t               wb_data_in,
  input  reg_addr_t           rs1_reg,
  input  reg_addr_t           rs2_reg,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                issue_en,
  input  reg_addr_t           issue_rd,
  output word_t               rs1_data,
  output word_t               rs2_data,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    wb_count
);

  word_t            regs_q [NUM_REGS];
  logic [CNT_W-1:0] wb_count_q, wb_count_d;
  logic             wr_fire;

  assign wr_fire    = wb_en_in && (wb_reg_in != ZERO_REG);
  assign wb_count_d = wb_count_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      wb_count_q <= '0;
    end else if (wr_fire) begin
      regs_q[wb_reg_in] <= wb_data_in;
      wb_count_q        <= wb_count_d;
    end
  end

  function automatic word_t read_port(input reg_addr_t rs);
    if (rs == ZERO_REG)
      return '0;
    else if (wb_en_in && (wb_reg_in == rs))
      return wb_data_in;
    else
      return regs_q[rs];
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_reg);
    rs2_data = read_port(rs2_reg);
  end

  assign wb_count = wb_count_q;

  rv32i_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wb_en_i    (wb_en_in),
    .wb_reg_i   (wb_reg_in),
    .rs1_reg_i  (rs1_reg),
    .rs2_reg_i  (rs2_reg),
    .rs1_used_i (rs1_used),
    .rs2_used_i (rs2_used),
    .issue_en_i (issue_en),
    .issue_rd_i (issue_rd),
    .stall_o    (stall),
    .busy_mask_o(busy_mask)
  );

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Directed self-checking bench for rv32i_regfile_sb.
module tb_rv32i_regfile_sb;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en_in;
  reg_addr_t   wb_reg_in;
  word_t       wb_data_in;
  reg_addr_t   rs1_reg, rs2_reg;
  logic        rs1_used, rs2_used;
  logic        issue_en;
  reg_addr_t   issue_rd;
  word_t       rs1_data, rs2_data;
  logic        stall;
  logic [31:0] busy_mask;
  logic [31:0] wb_count;

  int vectors    = 0;
  int miscompares = 0;

  rv32i_regfile_sb dut (
    .clk       (clk),
    .reset     (reset),
    .wb_en_in  (wb_en_in),
    .wb_reg_in (wb_reg_in),
    .wb_data_in(wb_data_in),
    .rs1_reg   (rs1_reg),
    .rs2_reg   (rs2_reg),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .stall     (stall),
    .busy_mask (busy_mask),
    .wb_count  (wb_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; wb_en_in = 1'b0; wb_reg_in = '0; wb_data_in = '0;
    rs1_reg = '0; rs2_reg = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_en = 1'b0; issue_rd = '0;

    tick();
    rs1_reg = 5'd5;
    #1;
    chk("rst_rs1", rs1_data, 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_count", wb_count, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);

    // Basic write then read from array
    reset = 1'b1;
    wb_en_in = 1'b1; wb_reg_in = 5'd5; wb_data_in = 32'hDEADBEEF;
    tick();
    wb_en_in = 1'b0;
    #1;
    chk("wr_x5", rs1_data, 32'hDEADBEEF);
    chk("wr_count1", wb_count, 32'd1);

    // Same-cycle bypass on both ports
    wb_en_in = 1'b1; wb_reg_in = 5'd9; wb_data_in = 32'h12345678;
    rs1_reg = 5'd9; rs2_reg = 5'd9;
    #1;
    chk("byp_rs1", rs1_data, 32'h12345678);
    chk("byp_rs2", rs2_data, 32'h12345678);
    tick();
    wb_en_in = 1'b0;
    #1;
    chk("arr_x9", rs2_data, 32'h12345678);
    chk("wr_count2", wb_count, 32'd2);

    // x0 is immutable and never busy
    wb_en_in = 1'b1; wb_reg_in = 5'd0; wb_data_in = 32'hFFFFFFFF;
    rs1_reg = 5'd0; issue_en = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_byp", rs1_data, 32'h0);
    tick();
    wb_en_in = 1'b0; issue_en = 1'b0;
    #1;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_count", wb_count, 32'd2);
    chk("x0_busy", busy_mask, 32'h0);

    // RAW hazard on x7
    issue_en = 1'b1; issue_rd = 5'd7;
    #1;
    chk("issue7_stall", {31'b0, stall}, 32'h0);
    tick();
    rs1_reg = 5'd7; rs1_used = 1'b1; issue_rd = 5'd8;
    #1;
    chk("raw_busy", busy_mask, 32'h80);
    chk("raw_stall", {31'b0, stall}, 32'h1);
    tick();
    #1;
    chk("raw_hold_busy", busy_mask, 32'h80);
    chk("raw_hold_stall", {31'b0, stall}, 32'h1);
    issue_en = 1'b0;
    wb_en_in = 1'b1; wb_reg_in = 5'd7; wb_data_in = 32'hA5A5A5A5;
    #1;
    chk("raw_wb_stall", {31'b0, stall}, 32'h0);
    chk("raw_wb_byp", rs1_data, 32'hA5A5A5A5);
    tick();
    wb_en_in = 1'b0; rs1_used = 1'b0;
    #1;
    chk("raw_clear", busy_mask, 32'h0);
    chk("raw_count", wb_count, 32'd3);

    // Hazard through the rs2 port only
    issue_en = 1'b1; issue_rd = 5'd12;
    tick();
    issue_en = 1'b0; rs1_reg = 5'd12; rs2_reg = 5'd12; rs2_used = 1'b1;
    #1;
    chk("rs2_stall", {31'b0, stall}, 32'h1);
    wb_en_in = 1'b1; wb_reg_in = 5'd12; wb_data_in = 32'h0000C0DE;
    tick();
    wb_en_in = 1'b0; rs2_used = 1'b0;
    #1;
    chk("rs2_clear", busy_mask, 32'h0);
    chk("rs2_read", rs2_data, 32'h0000C0DE);

    // Simultaneous set and clear on x3: set wins
    issue_en = 1'b1; issue_rd = 5'd3;
    wb_en_in = 1'b1; wb_reg_in = 5'd3; wb_data_in = 32'h33;
    tick();
    issue_en = 1'b0;
    wb_data_in = 32'h44;
    #1;
    chk("setwin_busy", busy_mask, 32'h8);
    tick();
    wb_en_in = 1'b0;
    #1;
    chk("x3_clear", busy_mask, 32'h0);
    chk("x3_count", wb_count, 32'd6);

    // Reset mid-operation
    for (int i = 1; i <= 4; i++) begin
      wb_en_in = 1'b1; wb_reg_in = reg_addr_t'(i); wb_data_in = 32'h11 * i;
      tick();
    end
    wb_en_in = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd6;
    tick();
    issue_en = 1'b0;
    rs1_reg = 5'd6; rs1_used = 1'b1; rs2_reg = 5'd2;
    #1;
    chk("pre_rst_busy", busy_mask, 32'h40);
    chk("pre_rst_count", wb_count, 32'd10);
    chk("pre_rst_x2", rs2_data, 32'h22);
    chk("pre_rst_stall", {31'b0, stall}, 32'h1);
    reset = 1'b0;
    wb_en_in = 1'b1; wb_reg_in = 5'd2; wb_data_in = 32'hBAD0BAD0;
    #1;
    chk("in_rst_stall", {31'b0, stall}, 32'h0);
    tick();
    reset = 1'b1; wb_en_in = 1'b0; rs1_used = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rs1_reg = reg_addr_t'(i);
      #1;
      chk($sformatf("post_rst_x%0d", i), rs1_data, 32'h0);
    end
    rs2_reg = 5'd7;
    #1;
    chk("post_rst_x7", rs2_data, 32'h0);
    chk("post_rst_busy", busy_mask, 32'h0);
    chk("post_rst_count", wb_count, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32i_regfile_sb.md
Name: rv32i_regfile_sb

Overview:
- Register-interface end of the RV32I writeback path: 32x32 integer register file plus an in-flight-write scoreboard.
- Consumes the writeback stage's enable/register/data triple and provides two combinational read ports to Instruction Decode.
- Read ports have write-through bypass.
- Tracks destination registers with pending writebacks and raises a decode stall on read-after-write hazards.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers (x0 hardwired to zero).
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low (0 = reset).
- wb_en_in  input  1  writeback enable from the writeback stage.
- wb_reg_in  input  5  writeback destination register.
- wb_data_in  input  XLEN  writeback data.
- rs1_reg  input  5  decode source register 1 address.
- rs2_reg  input  5  decode source register 2 address.
- rs1_used  input  1  instruction in decode actually reads rs1.
- rs2_used  input  1  instruction in decode actually reads rs2.
- issue_en  input  1  decode attempts to issue an instruction that writes rd.
- issue_rd  input  5  destination of the issuing instruction.
- rs1_data  output  XLEN  source 1 operand.
- rs2_data  output  XLEN  source 2 operand.
- stall  output  1  decode must hold; the issue is not accepted.
- busy_mask  output  NUM_REGS  scoreboard bits; bit i set means xi has a pending write.
- wb_count  output  CNT_W  number of committed non-x0 writes.

Behaviour:
- Reset (reset==0 at posedge):
  - All registers, busy_mask and wb_count are set to 0.
  - Writes and issues sampled in that cycle are discarded.
  - While reset==0, stall is forced to 0.
  - rs1_data and rs2_data follow the array, which reads 0 after the first reset edge.
- Register write: at posedge, if wb_en_in and wb_reg_in!=0, the array entry takes wb_data_in and wb_count increments by 1.
  - wb_count wraps from 2^CNT_W-1 to 0.
  - wb_en_in with wb_reg_in==0 is a no-op: no write, no count.
- Read (combinational, zero latency):
  - rsX_reg==0 gives 0.
  - Else, if wb_en_in and wb_reg_in==rsX_reg, the output is wb_data_in (write-through bypass).
  - Else the output is the array entry.
  - Both ports may read the same register.
- Scoreboard:
  - accept = issue_en && !stall && reset. busy bit 0 is always 0.
  - Clear: wb_en_in clears busy[wb_reg_in].
  - Set: accept with issue_rd!=0 sets busy[issue_rd].
  - Same register cleared and set in one cycle: set wins, because the new producer supersedes the old one. busy stays 1.
  - Clear of a register that is not busy is harmless.
- Hazard:
  - hazX = rsX_used && rsX_reg!=0 && busy[rsX_reg] && !(wb_en_in && wb_reg_in==rsX_reg).
  - stall = haz1 || haz2.
  - A writeback arriving in the same cycle resolves the hazard through the bypass, so there is no stall in that cycle.
- Stall semantics:
  - No scoreboard set while stall==1. Clears still proceed.
  - Decode holds its inputs stable and retries the next cycle.
- Latency:
  - Write is visible in the array on the cycle after wb_en_in, and through the bypass in the same cycle.
  - busy_mask updates one cycle after the accept or writeback.
- No internal reset sequencing; the block is ready on the first cycle with reset==1.

Decomposition:
- rv32i_pkg holds:
  - XLEN and REG_ADDR_W=5.
  - ZERO_REG=5'd0.
  - typedef word_t (logic [XLEN-1:0]).
  - typedef reg_addr_t (logic [4:0]).
- Sub-module rv32i_scoreboard holds busy_mask, the set/clear priority logic and the hazard/stall generation.
- The top level holds the array, bypass muxes and counter.

Test Plan:
- Reset, then wb_en_in=1, wb_reg_in=5, wb_data_in=0xDEADBEEF for one cycle; next cycle rs1_reg=5 -> rs1_data=0xDEADBEEF, wb_count=1.
- Same-cycle bypass: wb_en_in=1, wb_reg_in=9, wb_data_in=0x12345678 with rs1_reg=rs2_reg=9 -> both outputs 0x12345678 in that cycle.
- Write to x0 with data 0xFFFFFFFF -> rs1_reg=0 reads 0, wb_count unchanged, busy_mask[0]=0 even after issue_rd=0.
- RAW stall: accept issue_rd=7; next cycle rs1_reg=7, rs1_used=1 -> stall=1 and busy_mask=0x80.
  - stall stays 1 until wb_en_in, wb_reg_in=7 (data 0xA5A5A5A5); in that cycle stall=0 and rs1_data=0xA5A5A5A5; next cycle busy_mask=0.
- Simultaneous writeback and accepted issue both targeting x3 -> busy_mask[3] remains 1; a separate writeback to x3 clears it.
- Reset mid-operation: x1..x4 written, x6 busy; drive reset=0 for one cycle alongside wb_en_in to x2 -> all reads 0, busy_mask=0, wb_count=0, stall=0 during reset, x2 not written.
